// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm controller.
// Holds the FSM state encoding and the set-time range checks.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam logic [7:0] HH_MIN  = 8'h01;
    localparam logic [7:0] HH_MAX  = 8'h12;
    localparam logic [7:0] MM_MAX  = 8'h59;
    localparam logic [7:0] SS_ZERO = 8'h00;

    // Hour must be BCD 01-12 with a decimal low nibble.
    function automatic logic hh_ok(input logic [7:0] v);
        return (v >= HH_MIN) && (v <= HH_MAX) && (v[3:0] <= 4'h9);
    endfunction

    // Minute must be BCD 00-59; the upper bound also limits the tens nibble.
    function automatic logic mm_ok(input logic [7:0] v);
        return (v <= MM_MAX) && (v[3:0] <= 4'h9);
    endfunction

endpackage

// File: rtl/alarm_tick_counter.sv
// Loadable down-counter paced by the 1 Hz tick.
// Flags the final second so the FSM can act on the expiring tick.
module alarm_tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] count;

    // Load wins over decrement; a zero count never decrements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stored alarm time, ring/snooze/timeout sequencing.
// Every output is a flop; inputs reach outputs only through the FSM.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            tick,
    input  logic [7:0]                      hh,
    input  logic [7:0]                      mm,
    input  logic [7:0]                      ss,
    input  logic                            pm,
    input  logic                            arm,
    input  logic                            set_en,
    input  logic [7:0]                      set_hh,
    input  logic [7:0]                      set_mm,
    input  logic                            set_pm,
    input  logic                            snooze,
    input  logic                            stop,
    output logic [7:0]                      alarm_hh,
    output logic [7:0]                      alarm_mm,
    output logic                            alarm_pm,
    output logic                            ringing,
    output logic                            snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt,
    output logic                            set_err,
    output logic                            missed
);

    localparam int RW = $clog2(RING_SECS + 1);
    localparam int SW = $clog2(SNOOZE_SECS + 1);
    localparam int CW = $clog2(MAX_SNOOZE + 1);

    state_t state;

    logic set_ok;
    logic hold;
    logic match;
    logic start;
    logic stop_hit;
    logic snz_go;
    logic ring_tick;
    logic ring_out;
    logic snz_tick;
    logic rering;
    logic ring_last;
    logic snz_last;

    assign set_ok = set_en & hh_ok(set_hh) & mm_ok(set_mm);

    // Accepted set or disarm overrides every other request.
    assign hold = set_ok | ~arm;

    assign match = arm & tick & (hh == alarm_hh) & (mm == alarm_mm)
                 & (pm == alarm_pm) & (ss == SS_ZERO);

    assign start    = ~hold & (state == IDLE) & match;
    assign stop_hit = ~hold & (state != IDLE) & stop;
    assign snz_go   = ~hold & (state == RINGING) & ~stop & snooze
                    & (snooze_cnt < CW'(MAX_SNOOZE));
    // A snooze taken this cycle swallows a coincident tick.
    assign ring_tick = ~hold & (state == RINGING) & ~stop & ~snz_go & tick;
    assign ring_out  = ring_tick & ring_last;
    assign snz_tick  = ~hold & (state == SNOOZE) & ~stop & tick;
    assign rering    = snz_tick & snz_last;

    alarm_tick_counter #(.W(RW)) u_ring_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (start | rering),
        .load_val (RW'(RING_SECS)),
        .dec      (ring_tick),
        .last     (ring_last)
    );

    alarm_tick_counter #(.W(SW)) u_snz_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (snz_go),
        .load_val (SW'(SNOOZE_SECS)),
        .dec      (snz_tick),
        .last     (snz_last)
    );

    // Alarm registers, error/timeout pulses and the ring/snooze FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_hh   <= HH_MAX;
            alarm_mm   <= 8'h00;
            alarm_pm   <= 1'b0;
            state      <= IDLE;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            snooze_cnt <= '0;
            set_err    <= 1'b0;
            missed     <= 1'b0;
        end else begin
            set_err <= set_en & ~set_ok;
            missed  <= ring_out;
            if (set_ok) begin
                alarm_hh <= set_hh;
                alarm_mm <= set_mm;
                alarm_pm <= set_pm;
            end
            if (hold) begin
                state      <= IDLE;
                ringing    <= 1'b0;
                snoozing   <= 1'b0;
                snooze_cnt <= '0;
            end else begin
                unique case (1'b1)
                    start: begin
                        state      <= RINGING;
                        ringing    <= 1'b1;
                        snoozing   <= 1'b0;
                        snooze_cnt <= '0;
                    end
                    stop_hit: begin
                        state      <= IDLE;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b0;
                        snooze_cnt <= '0;
                    end
                    snz_go: begin
                        state      <= SNOOZE;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b1;
                        snooze_cnt <= snooze_cnt + 1'b1;
                    end
                    ring_out: begin
                        state      <= IDLE;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b0;
                        snooze_cnt <= '0;
                    end
                    rering: begin
                        state    <= RINGING;
                        ringing  <= 1'b1;
                        snoozing <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with a behavioural reference model.
// Model is compared on every falling edge; literal checks pin key moments.
module tb_alarm_ctrl;

    localparam int RS = 5;
    localparam int SN = 3;
    localparam int MS = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] hh = 8'h12;
    logic [7:0] mm = 8'h00;
    logic [7:0] ss = 8'h00;
    logic       pm = 1'b0;
    logic       arm = 1'b0;
    logic       set_en = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic       set_pm = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;

    logic [7:0] alarm_hh;
    logic [7:0] alarm_mm;
    logic       alarm_pm;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;
    logic       set_err;
    logic       missed;

    int errors = 0;
    int checks = 0;
    bit live = 1'b0;

    int th = 12;
    int tm = 0;
    int ts = 0;
    bit tp = 1'b0;

    // Model state: mode 0 = quiet, 1 = ringing, 2 = snoozing
    int         m_mode = 0;
    int         m_ring_left = 0;
    int         m_snz_left = 0;
    int         m_used = 0;
    logic [7:0] m_ahh = 8'h12;
    logic [7:0] m_amm = 8'h00;
    bit         m_apm = 1'b0;
    bit         m_err = 1'b0;
    bit         m_missed = 1'b0;
    bit         m_ok;

    alarm_ctrl #(
        .RING_SECS   (RS),
        .SNOOZE_SECS (SN),
        .MAX_SNOOZE  (MS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .pm         (pm),
        .arm        (arm),
        .set_en     (set_en),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_pm     (set_pm),
        .snooze     (snooze),
        .stop       (stop),
        .alarm_hh   (alarm_hh),
        .alarm_mm   (alarm_mm),
        .alarm_pm   (alarm_pm),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt),
        .set_err    (set_err),
        .missed     (missed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic bit legal(input logic [7:0] h, input logic [7:0] m);
        int hv;
        int mv;
        if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9) return 1'b0;
        hv = h[7:4] * 10 + h[3:0];
        mv = m[7:4] * 10 + m[3:0];
        return (hv >= 1) && (hv <= 12) && (mv <= 59);
    endfunction

    task automatic show_time();
        hh = to_bcd(th);
        mm = to_bcd(tm);
        ss = to_bcd(ts);
        pm = tp;
    endtask

    task automatic set_time(input int h, input int m, input int s, input bit p);
        th = h;
        tm = m;
        ts = s;
        tp = p;
        show_time();
    endtask

    task automatic advance();
        ts++;
        if (ts == 60) begin
            ts = 0;
            tm++;
            if (tm == 60) begin
                tm = 0;
                th = (th == 12) ? 1 : th + 1;
                if (th == 12) tp = ~tp;
            end
        end
    endtask

    // One clk with the chosen request lines high; the clock moves on a tick.
    task automatic drive(input bit sz, input bit st, input bit tk);
        @(negedge clk);
        snooze = sz;
        stop = st;
        tick = tk;
        @(negedge clk);
        snooze = 1'b0;
        stop = 1'b0;
        tick = 1'b0;
        if (tk) begin
            advance();
            show_time();
        end
    endtask

    task automatic tk();
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic pulse_set(input logic [7:0] h, input logic [7:0] m,
                             input bit p);
        @(negedge clk);
        set_en = 1'b1;
        set_hh = h;
        set_mm = m;
        set_pm = p;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    // Reference behaviour, written as plain priority rules over seconds left.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0;
            m_ring_left = 0;
            m_snz_left = 0;
            m_used = 0;
            m_ahh = 8'h12;
            m_amm = 8'h00;
            m_apm = 1'b0;
            m_err = 1'b0;
            m_missed = 1'b0;
        end else begin
            m_ok = set_en && legal(set_hh, set_mm);
            m_err = set_en && !m_ok;
            m_missed = 1'b0;
            if (m_ok) begin
                m_ahh = set_hh;
                m_amm = set_mm;
                m_apm = set_pm;
                m_mode = 0;
                m_used = 0;
            end else if (!arm) begin
                m_mode = 0;
                m_used = 0;
            end else if (m_mode == 0) begin
                if (tick && hh == m_ahh && mm == m_amm && pm == m_apm
                    && ss == 8'h00) begin
                    m_mode = 1;
                    m_ring_left = RS;
                    m_used = 0;
                end
            end else if (m_mode == 1) begin
                if (stop) begin
                    m_mode = 0;
                    m_used = 0;
                end else if (snooze && m_used < MS) begin
                    m_mode = 2;
                    m_snz_left = SN;
                    m_used++;
                end else if (tick) begin
                    m_ring_left--;
                    if (m_ring_left == 0) begin
                        m_mode = 0;
                        m_missed = 1'b1;
                        m_used = 0;
                    end
                end
            end else begin
                if (stop) begin
                    m_mode = 0;
                    m_used = 0;
                end else if (tick) begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin
                        m_mode = 1;
                        m_ring_left = RS;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live && reset_n) begin
            chk("ringing", ringing, m_mode == 1);
            chk("snoozing", snoozing, m_mode == 2);
            chk("snooze_cnt", snooze_cnt, m_used);
            chk("set_err", set_err, m_err);
            chk("missed", missed, m_missed);
            chk("alarm_hh", alarm_hh, m_ahh);
            chk("alarm_mm", alarm_mm, m_amm);
            chk("alarm_pm", alarm_pm, m_apm);
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_alarm_hh", alarm_hh, 8'h12);
        chk("rst_alarm_mm", alarm_mm, 8'h00);
        chk("rst_ringing", ringing, 1'b0);
        chk("rst_set_err", set_err, 1'b0);
        reset_n = 1'b1;
        live = 1'b1;

        // Alarm at 07:30 AM, first edge into :00 must stay quiet
        set_time(7, 29, 59, 1'b0);
        arm = 1'b1;
        pulse_set(8'h07, 8'h30, 1'b0);
        chk("set0730_hh", alarm_hh, 8'h07);
        tk();
        chk("edge_into_00", ringing, 1'b0);
        tk();
        chk("ring_at_00", ringing, 1'b1);

        // Auto timeout after RS ticks
        repeat (4) tk();
        chk("still_ring", ringing, 1'b1);
        tk();
        chk("timeout_ring", ringing, 1'b0);
        chk("timeout_missed", missed, 1'b1);
        chk("timeout_cnt", snooze_cnt, 2'd0);
        @(negedge clk);
        chk("missed_once", missed, 1'b0);
        repeat (54) tk();
        chk("no_rering_minute", ringing, 1'b0);

        // Snooze twice, third ignored, then stop
        set_time(7, 30, 0, 1'b0);
        tk();
        chk("ring2", ringing, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        chk("snz1_on", snoozing, 1'b1);
        chk("snz1_cnt", snooze_cnt, 2'd1);
        tk();
        tk();
        chk("snz1_hold", snoozing, 1'b1);
        tk();
        chk("rering1", ringing, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        chk("snz2_cnt", snooze_cnt, 2'd2);
        repeat (3) tk();
        chk("rering2", ringing, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        chk("snz3_ignored", ringing, 1'b1);
        chk("snz3_cnt", snooze_cnt, 2'd2);
        drive(1'b0, 1'b1, 1'b0);
        chk("stop_ring", ringing, 1'b0);
        chk("stop_cnt", snooze_cnt, 2'd0);

        // Rejected and accepted sets
        pulse_set(8'h13, 8'h00, 1'b0);
        chk("bad_hh_err", set_err, 1'b1);
        chk("bad_hh_keep", alarm_hh, 8'h07);
        @(negedge clk);
        chk("err_pulse", set_err, 1'b0);
        pulse_set(8'h07, 8'h5A, 1'b0);
        chk("bad_mm_err", set_err, 1'b1);
        chk("bad_mm_keep", alarm_mm, 8'h30);
        pulse_set(8'h00, 8'h30, 1'b0);
        chk("zero_hh_err", set_err, 1'b1);
        pulse_set(8'h12, 8'h00, 1'b1);
        chk("good_err", set_err, 1'b0);
        chk("good_hh", alarm_hh, 8'h12);
        chk("good_mm", alarm_mm, 8'h00);
        chk("good_pm", alarm_pm, 1'b1);

        // Stop beats snooze; snooze beats tick; pm mismatch never rings
        set_time(12, 0, 0, 1'b1);
        tk();
        chk("ring_pm", ringing, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("stop_snz_ring", ringing, 1'b0);
        chk("stop_snz_snz", snoozing, 1'b0);
        set_time(12, 0, 0, 1'b1);
        tk();
        tk();
        tk();
        drive(1'b1, 1'b0, 1'b1);
        chk("snz_tick_snz", snoozing, 1'b1);
        chk("snz_tick_cnt", snooze_cnt, 2'd1);
        repeat (3) tk();
        chk("reload_ring", ringing, 1'b1);
        repeat (4) tk();
        chk("reload_still", ringing, 1'b1);
        tk();
        chk("reload_missed", missed, 1'b1);
        set_time(12, 0, 0, 1'b0);
        tk();
        chk("pm_mismatch", ringing, 1'b0);

        // Async reset mid-snooze
        set_time(12, 0, 0, 1'b1);
        tk();
        drive(1'b1, 1'b0, 1'b0);
        chk("pre_rst_snz", snoozing, 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_snz", snoozing, 1'b0);
        chk("async_hh", alarm_hh, 8'h12);
        chk("async_mm", alarm_mm, 8'h00);
        chk("async_pm", alarm_pm, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Disarm while ringing
        set_time(12, 0, 0, 1'b0);
        tk();
        chk("ring_am", ringing, 1'b1);
        @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
        chk("disarm_ring", ringing, 1'b0);
        chk("disarm_missed", missed, 1'b0);
        arm = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
